// File: rtl/mpu_matrix_loader_if.sv
// Matrix loader handshake bundle: cfg start, element stream, packed matrix output.
// master = upstream/consumer side driving requests, slave = the loader.
interface mpu_matrix_loader_if #(
   parameter int N_MAX = 5,
   parameter int W     = 8
);
   logic                       cfg_valid;
   logic [7:0]                 cfg_size;
   logic                       cfg_ready;
   logic                       in_valid;
   logic [W-1:0]               in_data;
   logic                       in_ready;
   logic [0:W*N_MAX*N_MAX-1]   matrix;
   logic [7:0]                 size;
   logic                       out_valid;
   logic                       out_ready;

   modport master (
      output cfg_valid, cfg_size, in_valid, in_data, out_ready,
      input  cfg_ready, in_ready, matrix, size, out_valid
   );

   modport slave (
      input  cfg_valid, cfg_size, in_valid, in_data, out_ready,
      output cfg_ready, in_ready, matrix, size, out_valid
   );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Packs a row-major int8 stream of a 1..N_MAX square matrix into a zero-filled 5x5 bus.
// out_valid one cycle after the last element; matrix held until out_ready, inputs stalled meanwhile.
module mpu_matrix_loader #(
   parameter int N_MAX = 5,
   parameter int W     = 8
) (
   input  logic                 clock_i,
   input  logic                 reset_n_i,
   input  logic                 abort_i,
   output logic                 busy_o,
   output logic                 error_o,
   mpu_matrix_loader_if.slave   bus
);
   localparam int MW = W * N_MAX * N_MAX;
   localparam int RW = $clog2(N_MAX + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_HOLD} state_t;

   state_t           state_q, state_d;
   logic [0:MW-1]    matrix_q, matrix_d;
   logic [7:0]       size_q, size_d;
   logic [RW-1:0]    row_q, row_d;
   logic [RW-1:0]    col_q, col_d;
   logic             error_q, error_d;

   logic             cfg_legal;
   logic [7:0]       size_m1;
   logic             last_col;
   logic             last_row;
   int               elem_base;

   // cfg_size is signed: reject zero, negatives and anything above N_MAX
   assign cfg_legal = !bus.cfg_size[7] && (bus.cfg_size != 8'd0) && (bus.cfg_size <= 8'(N_MAX));
   assign size_m1   = size_q - 8'd1;
   assign last_col  = ({{(8-RW){1'b0}}, col_q} == size_m1);
   assign last_row  = ({{(8-RW){1'b0}}, row_q} == size_m1);
   assign elem_base = (int'(row_q) * N_MAX + int'(col_q)) * W;

   always_comb begin
      state_d  = state_q;
      matrix_d = matrix_q;
      size_d   = size_q;
      row_d    = row_q;
      col_d    = col_q;
      error_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.cfg_valid) begin
               if (cfg_legal) begin
                  matrix_d = '0;
                  size_d   = bus.cfg_size;
                  row_d    = '0;
                  col_d    = '0;
                  state_d  = ST_LOAD;
               end else begin
                  error_d  = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (bus.in_valid) begin
               matrix_d[elem_base +: W] = bus.in_data;
               if (last_col) begin
                  col_d = '0;
                  if (last_row) begin
                     row_d   = '0;
                     state_d = ST_HOLD;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // abort overrides whatever the handshakes asked for this cycle
      if (abort_i) begin
         state_d  = ST_IDLE;
         matrix_d = '0;
         size_d   = 8'd0;
         row_d    = '0;
         col_d    = '0;
         error_d  = 1'b0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q  <= ST_IDLE;
         matrix_q <= '0;
         size_q   <= 8'd0;
         row_q    <= '0;
         col_q    <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         matrix_q <= matrix_d;
         size_q   <= size_d;
         row_q    <= row_d;
         col_q    <= col_d;
         error_q  <= error_d;
      end
   end

   assign bus.cfg_ready = (state_q == ST_IDLE);
   assign bus.in_ready  = (state_q == ST_LOAD);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.matrix    = matrix_q;
   assign bus.size      = size_q;
   assign busy_o        = (state_q != ST_IDLE);
   assign error_o       = error_q;
endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader: packing, gaps, hold stall, illegal sizes, shrink, reset/abort.
module tb_mpu_matrix_loader;
   localparam int N_MAX = 5;
   localparam int W     = 8;
   localparam int MW    = W * N_MAX * N_MAX;

   logic clock;
   logic reset_n;
   logic abort;
   logic busy;
   logic error;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0]    stim [25];
   logic [0:MW-1] exp_m;

   mpu_matrix_loader_if #(.N_MAX(N_MAX), .W(W)) bus ();

   mpu_matrix_loader #(.N_MAX(N_MAX), .W(W)) dut (
      .clock_i   (clock),
      .reset_n_i (reset_n),
      .abort_i   (abort),
      .busy_o    (busy),
      .error_o   (error),
      .bus       (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      abort         = 1'b0;
      bus.cfg_valid = 1'b0;
      bus.cfg_size  = 8'd0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'd0;
      bus.out_ready = 1'b0;
   endtask

   function automatic void set_el(input int r, input int c, input logic [7:0] v);
      exp_m[(r*N_MAX*W + c*W) +: W] = v;
   endfunction

   task automatic start(input logic [7:0] sz);
      bus.cfg_valid = 1'b1;
      bus.cfg_size  = sz;
      tick();
      bus.cfg_valid = 1'b0;
   endtask

   task automatic send_elems(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = stim[i];
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic release_hold();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tests_run++;
      if (bus.matrix !== '0) begin
         tests_failed++; $display("FAIL reset_matrix got=%h exp=0", bus.matrix);
      end
      tests_run++;
      if (bus.size !== 8'd0) begin
         tests_failed++; $display("FAIL reset_size got=%0d exp=0", bus.size);
      end
      tests_run++;
      if ({bus.out_valid, error, busy, bus.in_ready, bus.cfg_ready} !== 5'b00001) begin
         tests_failed++;
         $display("FAIL reset_flags got=%b exp=00001 (out_valid,error,busy,in_ready,cfg_ready)",
                  {bus.out_valid, error, busy, bus.in_ready, bus.cfg_ready});
      end
   endtask

   task automatic test_load_2x2();
      start(8'd2);
      tests_run++;
      if ({bus.cfg_ready, bus.in_ready, busy} !== 3'b011) begin
         tests_failed++; $display("FAIL t1_load_state got=%b exp=011", {bus.cfg_ready, bus.in_ready, busy});
      end
      stim[0] = 8'd3; stim[1] = 8'd1; stim[2] = 8'd2; stim[3] = 8'd4;
      send_elems(0, 3);
      tests_run++;
      if (bus.out_valid !== 1'b0) begin
         tests_failed++; $display("FAIL t1_early_valid got=%b exp=0", bus.out_valid);
      end
      send_elems(3, 1);
      tests_run++;
      if (bus.out_valid !== 1'b1) begin
         tests_failed++; $display("FAIL t1_out_valid got=%b exp=1", bus.out_valid);
      end
      exp_m = '0;
      set_el(0, 0, 8'd3); set_el(0, 1, 8'd1); set_el(1, 0, 8'd2); set_el(1, 1, 8'd4);
      tests_run++;
      if (bus.matrix !== exp_m) begin
         tests_failed++; $display("FAIL t1_matrix got=%h exp=%h", bus.matrix, exp_m);
      end
      tests_run++;
      if (bus.size !== 8'd2) begin
         tests_failed++; $display("FAIL t1_size got=%0d exp=2", bus.size);
      end
      release_hold();
      tests_run++;
      if ({bus.out_valid, bus.cfg_ready} !== 2'b01) begin
         tests_failed++; $display("FAIL t1_release got=%b exp=01", {bus.out_valid, bus.cfg_ready});
      end
   endtask

   task automatic test_load_5x5_gaps();
      int sent  = 0;
      int cyc   = 0;
      int early = 0;
      start(8'd5);
      while (sent < 25 && cyc < 100) begin
         cyc++;
         if (cyc % 3 == 0) begin
            bus.in_valid = 1'b0;
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(sent + 1);
            sent++;
         end
         tick();
         if (sent < 25 && bus.out_valid) early++;
      end
      bus.in_valid = 1'b0;
      tests_run++;
      if (early != 0 || cyc != 37) begin
         tests_failed++; $display("FAIL t2_timing early_valid=%0d cycles=%0d exp 0 and 37", early, cyc);
      end
      tests_run++;
      if (bus.out_valid !== 1'b1) begin
         tests_failed++; $display("FAIL t2_out_valid got=%b exp=1", bus.out_valid);
      end
      exp_m = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            set_el(r, c, 8'(5*r + c + 1));
      tests_run++;
      if (bus.matrix !== exp_m) begin
         tests_failed++; $display("FAIL t2_matrix got=%h exp=%h", bus.matrix, exp_m);
      end
   endtask

   task automatic test_hold_stall();
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
         bus.out_ready = 1'b0;
         bus.cfg_valid = 1'b1;
         bus.cfg_size  = 8'd2;
         bus.in_valid  = 1'b1;
         bus.in_data   = 8'h55;
         tick();
         if (bus.matrix !== exp_m || bus.out_valid !== 1'b1 || bus.cfg_ready !== 1'b0 ||
             bus.in_ready !== 1'b0 || bus.size !== 8'd5) bad++;
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++; $display("FAIL t4_hold_stable bad_cycles=%0d exp=0", bad);
      end
      bus.cfg_valid = 1'b0;
      bus.in_valid  = 1'b0;
      release_hold();
      tests_run++;
      if ({bus.out_valid, bus.cfg_ready} !== 2'b01) begin
         tests_failed++; $display("FAIL t4_release got=%b exp=01", {bus.out_valid, bus.cfg_ready});
      end
      tick();
      tests_run++;
      if (bus.matrix !== exp_m || busy !== 1'b0) begin
         tests_failed++; $display("FAIL t4_idle_keep busy=%b matrix=%h exp busy=0 matrix=%h", busy, bus.matrix, exp_m);
      end
   endtask

   task automatic test_illegal_cfg();
      logic [7:0] bad_sz [3];
      bad_sz[0] = 8'd0; bad_sz[1] = 8'd6; bad_sz[2] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         bus.cfg_valid = 1'b1;
         bus.cfg_size  = bad_sz[i];
         tick();
         bus.cfg_valid = 1'b0;
         tests_run++;
         if ({error, bus.cfg_ready, busy} !== 3'b110) begin
            tests_failed++;
            $display("FAIL t3_error_pulse size=%0d got=%b exp=110 (error,cfg_ready,busy)",
                     $signed(bad_sz[i]), {error, bus.cfg_ready, busy});
         end
         tick();
         tests_run++;
         if (error !== 1'b0) begin
            tests_failed++; $display("FAIL t3_error_one_cycle size=%0d got=%b exp=0", $signed(bad_sz[i]), error);
         end
      end
      tests_run++;
      if (bus.matrix !== exp_m || bus.size !== 8'd5) begin
         tests_failed++; $display("FAIL t3_unchanged size=%0d matrix=%h exp size=5 matrix=%h", bus.size, bus.matrix, exp_m);
      end
   endtask

   task automatic test_shrink();
      logic [7:0] e00;
      for (int i = 0; i < 25; i++) stim[i] = 8'h7F;
      start(8'd5);
      send_elems(0, 25);
      release_hold();
      stim[0] = 8'h80; stim[1] = 8'd1; stim[2] = 8'd2; stim[3] = 8'd3; stim[4] = 8'd4;
      stim[5] = 8'd5;  stim[6] = 8'd6; stim[7] = 8'd7; stim[8] = 8'h81;
      start(8'd3);
      send_elems(0, 9);
      exp_m = '0;
      set_el(0, 0, 8'h80); set_el(0, 1, 8'd1); set_el(0, 2, 8'd2);
      set_el(1, 0, 8'd3);  set_el(1, 1, 8'd4); set_el(1, 2, 8'd5);
      set_el(2, 0, 8'd6);  set_el(2, 1, 8'd7); set_el(2, 2, 8'h81);
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.size !== 8'd3) begin
         tests_failed++; $display("FAIL t5_done out_valid=%b size=%0d exp 1 and 3", bus.out_valid, bus.size);
      end
      tests_run++;
      if (bus.matrix !== exp_m) begin
         tests_failed++; $display("FAIL t5_matrix got=%h exp=%h", bus.matrix, exp_m);
      end
      e00 = bus.matrix[0:7];
      tests_run++;
      if (e00 !== 8'h80) begin
         tests_failed++; $display("FAIL t5_elem00 got=%h exp=80", e00);
      end
      release_hold();
   endtask

   task automatic test_reset_mid_load();
      for (int i = 0; i < 7; i++) stim[i] = 8'(8'h10 + i);
      start(8'd4);
      send_elems(0, 7);
      tests_run++;
      if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
         tests_failed++; $display("FAIL t6_mid_load busy=%b in_ready=%b exp 1 1", busy, bus.in_ready);
      end
      reset_n = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      tick();
      reset_n = 1'b1;
      bus.in_valid = 1'b0;
      tests_run++;
      if (bus.matrix !== '0 || bus.size !== 8'd0 || bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL t6_reset matrix=%h size=%0d out_valid=%b cfg_ready=%b exp 0 0 0 1",
                  bus.matrix, bus.size, bus.out_valid, bus.cfg_ready);
      end
   endtask

   task automatic test_abort_hold();
      stim[0] = 8'd9; stim[1] = 8'd8; stim[2] = 8'd7; stim[3] = 8'd6;
      start(8'd2);
      send_elems(0, 4);
      tests_run++;
      if (bus.out_valid !== 1'b1) begin
         tests_failed++; $display("FAIL t6_pre_abort out_valid=%b exp=1", bus.out_valid);
      end
      abort         = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      abort         = 1'b0;
      bus.out_ready = 1'b0;
      tests_run++;
      if (bus.matrix !== '0 || bus.size !== 8'd0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL t6_abort matrix=%h size=%0d out_valid=%b busy=%b exp 0 0 0 0",
                  bus.matrix, bus.size, bus.out_valid, busy);
      end
   endtask

   task automatic test_fresh_load();
      stim[0] = 8'hF0; stim[1] = 8'h0F; stim[2] = 8'h80; stim[3] = 8'h7F;
      start(8'd2);
      send_elems(0, 4);
      exp_m = '0;
      set_el(0, 0, 8'hF0); set_el(0, 1, 8'h0F); set_el(1, 0, 8'h80); set_el(1, 1, 8'h7F);
      tests_run++;
      if (bus.matrix !== exp_m || bus.size !== 8'd2 || bus.out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL t6_fresh matrix=%h size=%0d out_valid=%b exp matrix=%h size=2 out_valid=1",
                  bus.matrix, bus.size, bus.out_valid, exp_m);
      end
      release_hold();
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_load_2x2();
      test_load_5x5_gaps();
      test_hold_stall();
      test_illegal_cfg();
      test_shrink();
      test_reset_mid_load();
      test_abort_hold();
      test_fresh_load();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
